fpga2_receiver: RTL and testbench



---
 rtl/fpga2_receiver.sv | 191 +++++++++++++++++++
 tb/tb_fpga2_receiver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga2_receiver.sv
// Receive side of the FPGA-to-FPGA link: synchronises link control, buffers one burst,
// acks or rejects it by length/timeout, then drains accepted words downstream.
module fpga2_receiver #(
    parameter int unsigned RECV_COUNT  = 10,
    parameter int unsigned MAX_WORDS   = 16,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned NACK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_in,
    input  logic        send_done_in,
    input  logic [31:0] data_in,
    output logic        rdy_out,
    output logic        ack_out,
    output logic [31:0] data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        done,
    output logic [7:0]  error_cnt
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PTR_W   = $clog2(RECV_COUNT + 1);
    localparam int unsigned CAP_W   = 10;
    localparam int unsigned CAP_MAX = 1023;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned NACK_W  = $clog2(NACK_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_RECEIVE,
        S_CHECK,
        S_ACK,
        S_NACK,
        S_DRAIN
    } state_t;

    state_t              state;
    logic                req_m, req_s;
    logic                sd_m, sd_s, sd_q;
    logic [DATA_W-1:0]   d_r;
    logic [DATA_W-1:0]   buf_mem [RECV_COUNT];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CAP_W-1:0]    cap_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [NACK_W-1:0]   nack_cnt;
    logic                sd_edge;
    logic                wr_en;
    logic [7:0]          err_next;

    // Two-flop synchronisers for the async link controls; data is only retimed.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
            sd_m  <= 1'b0;
            sd_s  <= 1'b0;
            sd_q  <= 1'b0;
            d_r   <= '0;
        end else begin
            req_m <= req_in;
            req_s <= req_m;
            sd_m  <= send_done_in;
            sd_s  <= sd_m;
            sd_q  <= sd_s;
            d_r   <= data_in;
        end
    end

    assign sd_edge  = sd_s & ~sd_q;
    assign wr_en    = (state == S_RECEIVE) && req_s && !sd_edge &&
                      (wr_ptr < PTR_W'(RECV_COUNT));
    assign err_next = (error_cnt == 8'hFF) ? error_cnt : error_cnt + 8'd1;

    // Burst buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_ptr] <= d_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rdy_out   <= 1'b0;
            ack_out   <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
            error_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cap_cnt   <= '0;
            tmo_cnt   <= '0;
            nack_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    rdy_out   <= 1'b0;
                    ack_out   <= 1'b0;
                    valid_out <= 1'b0;
                    if (req_s) begin
                        state   <= S_READY;
                        rdy_out <= 1'b1;
                    end
                end
                S_READY: begin
                    wr_ptr  <= '0;
                    cap_cnt <= '0;
                    tmo_cnt <= '0;
                    state   <= S_RECEIVE;
                end
                S_RECEIVE: begin
                    // Sender abort beats end-of-burst, which beats timeout.
                    if (!req_s) begin
                        state   <= S_IDLE;
                        rdy_out <= 1'b0;
                    end else if (sd_edge) begin
                        state <= S_CHECK;
                    end else begin
                        if (wr_ptr < PTR_W'(RECV_COUNT)) begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                        if (cap_cnt != CAP_W'(CAP_MAX)) begin
                            cap_cnt <= cap_cnt + CAP_W'(1);
                        end
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                            state     <= S_NACK;
                            rdy_out   <= 1'b0;
                            nack_cnt  <= '0;
                            error_cnt <= err_next;
                        end
                    end
                end
                S_CHECK: begin
                    if ((cap_cnt >= CAP_W'(RECV_COUNT)) && (cap_cnt <= CAP_W'(MAX_WORDS))) begin
                        state   <= S_ACK;
                        ack_out <= 1'b1;
                    end else begin
                        state     <= S_NACK;
                        rdy_out   <= 1'b0;
                        nack_cnt  <= '0;
                        error_cnt <= err_next;
                    end
                end
                S_ACK: begin
                    if (!req_s) begin
                        state     <= S_DRAIN;
                        ack_out   <= 1'b0;
                        rdy_out   <= 1'b0;
                        valid_out <= 1'b1;
                        data_out  <= buf_mem[0];
                        rd_ptr    <= '0;
                    end
                end
                S_NACK: begin
                    if (nack_cnt == NACK_W'(NACK_CYCLES - 1)) begin
                        if (req_s) begin
                            state   <= S_READY;
                            rdy_out <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        nack_cnt <= nack_cnt + NACK_W'(1);
                    end
                end
                S_DRAIN: begin
                    // data_out/valid_out only move on an accepted transfer.
                    if (valid_out && ready_in) begin
                        if (rd_ptr == PTR_W'(RECV_COUNT - 1)) begin
                            valid_out <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            rd_ptr   <= rd_ptr + PTR_W'(1);
                            data_out <= buf_mem[rd_ptr + PTR_W'(1)];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpga2_receiver.sv
// Directed bench for fpga2_receiver: good/short/timeout bursts, backpressure, aborts, saturation.
module tb_fpga2_receiver;
    localparam int unsigned RC = 10;

    logic        clk;
    logic        rst;
    logic        req_in;
    logic        send_done_in;
    logic [31:0] data_in;
    logic        rdy_out;
    logic        ack_out;
    logic [31:0] data_out;
    logic        valid_out;
    logic        ready_in;
    logic        done;
    logic [7:0]  error_cnt;

    int tests = 0;
    int fails = 0;

    fpga2_receiver #(
        .RECV_COUNT  (RC),
        .MAX_WORDS   (16),
        .TIMEOUT     (20),
        .NACK_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .send_done_in (send_done_in),
        .data_in      (data_in),
        .rdy_out      (rdy_out),
        .ack_out      (ack_out),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .done         (done),
        .error_cnt    (error_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for READY, then feed base+i each cycle; raise send_done at i == sd_at.
    task automatic run_burst(input logic [31:0] base, input int sd_at);
        int n;
        n = 0;
        while (rdy_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("rdy_within_4", 32'(n <= 4), 32'd1);
        for (int i = 0; i <= sd_at + 2; i++) begin
            data_in = base + 32'(i);
            if (i == sd_at) send_done_in = 1'b1;
            step();
        end
        send_done_in = 1'b0;
    endtask

    task automatic wait_nack(output int low_cnt);
        int g;
        g = 0;
        low_cnt = 0;
        while (rdy_out === 1'b1 && g < 40) begin
            step();
            g++;
        end
        while (rdy_out === 1'b0 && low_cnt < 40) begin
            low_cnt++;
            step();
        end
    endtask

    task automatic wait_ack_hold();
        int g;
        g = 0;
        while (ack_out !== 1'b1 && g < 10) begin
            step();
            g++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("ack_held", 32'(ack_out), 32'd1);
            chk("rdy_in_ack", 32'(rdy_out), 32'd1);
            step();
        end
    endtask

    task automatic drain(input logic [31:0] base, input bit bp);
        int g;
        int k;
        int cyc;
        g = 0;
        while (valid_out !== 1'b1 && g < 10) begin
            step();
            g++;
        end
        chk("drain_start", 32'(valid_out), 32'd1);
        chk("ack_low_drain", 32'(ack_out), 32'd0);
        k = 0;
        cyc = 0;
        while (k < int'(RC) && cyc < 100) begin
            ready_in = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            chk("drain_data", data_out, base + 32'(k));
            chk("drain_valid", 32'(valid_out), 32'd1);
            chk("drain_rdy_low", 32'(rdy_out), 32'd0);
            chk("drain_no_done", 32'(done), 32'd0);
            if (ready_in) k++;
            step();
            cyc++;
        end
        ready_in = 1'b0;
        chk("drain_end_valid", 32'(valid_out), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        step();
        chk("done_once", 32'(done), 32'd0);
    endtask

    initial begin
        int lc;
        int n_hi;
        int exp_err;
        logic ack_seen;

        rst          = 1'b1;
        req_in       = 1'b0;
        send_done_in = 1'b0;
        data_in      = '0;
        ready_in     = 1'b0;
        repeat (3) step();
        chk("rst_rdy", 32'(rdy_out), 32'd0);
        chk("rst_ack", 32'(ack_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Good burst, no backpressure
        req_in = 1'b1;
        run_burst(32'h100, 12);
        wait_ack_hold();
        req_in = 1'b0;
        drain(32'h100, 1'b0);
        chk("good_err", 32'(error_cnt), 32'd0);

        // Short burst, then retry drained under backpressure
        req_in = 1'b1;
        run_burst(32'h100, 5);
        wait_nack(lc);
        chk("short_nack_len", 32'(lc), 32'd4);
        chk("short_err", 32'(error_cnt), 32'd1);
        chk("short_rdy_back", 32'(rdy_out), 32'd1);
        run_burst(32'h200, 12);
        wait_ack_hold();
        req_in = 1'b0;
        drain(32'h200, 1'b1);

        // Timeout with no send_done
        req_in = 1'b1;
        n_hi = 0;
        while (rdy_out !== 1'b1 && n_hi < 20) begin
            step();
            n_hi++;
        end
        n_hi = 0;
        ack_seen = 1'b0;
        step();
        while (rdy_out === 1'b1 && n_hi < 40) begin
            ack_seen |= ack_out;
            n_hi++;
            step();
        end
        ack_seen |= ack_out;
        chk("timeout_len", 32'(n_hi), 32'd20);
        chk("timeout_no_ack", 32'(ack_seen), 32'd0);
        chk("timeout_err", 32'(error_cnt), 32'd2);
        req_in = 1'b0;
        repeat (8) step();
        chk("timeout_idle", 32'(rdy_out), 32'd0);

        // Abort mid-RECEIVE
        req_in = 1'b1;
        n_hi = 0;
        while (rdy_out !== 1'b1 && n_hi < 20) begin
            step();
            n_hi++;
        end
        repeat (5) step();
        req_in = 1'b0;
        repeat (5) step();
        chk("abort_rdy", 32'(rdy_out), 32'd0);
        chk("abort_ack", 32'(ack_out), 32'd0);
        repeat (30) step();
        chk("abort_err", 32'(error_cnt), 32'd2);
        chk("abort_idle", 32'(rdy_out), 32'd0);

        // Error counter saturation
        req_in = 1'b1;
        exp_err = 2;
        for (int b = 0; b < 260; b++) begin
            run_burst(32'h400 + 32'(b), 0);
            wait_nack(lc);
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
            chk("sat_nack_len", 32'(lc), 32'd4);
            chk("sat_err", 32'(error_cnt), 32'(exp_err));
        end
        chk("sat_final", 32'(error_cnt), 32'd255);

        // Reset during a stalled DRAIN
        run_burst(32'h300, 12);
        wait_ack_hold();
        req_in = 1'b0;
        lc = 0;
        while (valid_out !== 1'b1 && lc < 10) begin
            step();
            lc++;
        end
        ready_in = 1'b0;
        repeat (2) step();
        chk("stall_valid", 32'(valid_out), 32'd1);
        chk("stall_data", data_out, 32'h300);
        rst = 1'b1;
        step();
        chk("rst_drain_valid", 32'(valid_out), 32'd0);
        chk("rst_drain_data", data_out, 32'd0);
        chk("rst_drain_rdy", 32'(rdy_out), 32'd0);
        chk("rst_drain_ack", 32'(ack_out), 32'd0);
        chk("rst_drain_done", 32'(done), 32'd0);
        chk("rst_drain_err", 32'(error_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) step();
        chk("post_rst_valid", 32'(valid_out), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
